stack_cmd_master: RTL
=====================

// Module: stack_cmd_master
// PURPOSE
//  Initiator for the on-chip 8-bit LIFO stack's two-phase push/pop strobe interface. Accepts
//  NOP/PUSH/POP/FLUSH commands on a valid/ready port. Keeps a mirror of the stack's internal
//  step phase so that every strobe is held for exactly one step-0/step-1 pair. Tracks occupancy,
//  refuses overflow/underflow, and returns one response per command (pop data or error).
//  Sits between the host-side I/O decode and the stack instance.
// PARAMETERS
//  DW        8    data width; must match the stack's data width
//  DEPTH     256  stack entries; full when depth==DEPTH
//  FLUSH_CYC 1    cycles that stk_rst_n is held low on FLUSH (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      high only in IDLE; handshake is cmd_valid&cmd_ready
//  cmd_op     in   2      00 NOP, 01 PUSH, 10 POP, 11 FLUSH
//  cmd_data   in   DW     push data, sampled at handshake
//  rsp_valid  out  1      one-cycle pulse per accepted command; no backpressure
//  rsp_data   out  DW     popped value on POP, otherwise 0
//  rsp_err    out  1      PUSH while full or POP while empty
//  stk_push   out  1      to stack push strobe
//  stk_pop    out  1      to stack pop strobe
//  stk_wdata  out  DW     to stack data input; held stable while stk_push is high
//  stk_rdata  in   DW     from stack output register
//  stk_rst_n  out  1      to stack active-low reset: ~reset & ~flush_active (combinational)
//  depth      out  9      current occupancy, 0..DEPTH
//  full,empty out  1      depth==DEPTH / depth==0
// BEHAVIOUR
//  Reset: state=IDLE, phase=0, depth=0, and every other output and register is 0
//   (including stk_push, stk_pop, stk_wdata, rsp_*). stk_rst_n is low in the same cycle.
//  Phase mirror: if stk_rst_n is low in a cycle, phase<=0; otherwise phase<=~phase.
//   phase==0 corresponds to stack step 0 (write/decrement); phase==1 corresponds to step 1
//   (increment/read).
//  FSM IDLE -> {ALIGN} -> PH0 -> PH1 -> {CAPTURE} -> RESP -> IDLE:
//   IDLE: cmd_ready=1. On handshake, latch op and data.
//    - NOP, PUSH&full, POP&empty: go to RESP. No strobe is ever driven.
//    - FLUSH: go to FLUSH.
//    - Otherwise, if the next cycle's phase==0, go to PH0; else go to ALIGN.
//   ALIGN: one idle cycle, then PH0.
//   PH0 (phase==0) and PH1 (phase==1): the stk_push or stk_pop strobe is high for both cycles;
//    stk_wdata holds the latched data. The strobe is registered, so it is low in every other state.
//   After PH1: PUSH goes to RESP with depth+1. POP goes to CAPTURE with depth-1.
//   CAPTURE: the stack output register is valid now; rsp_data<=stk_rdata. Go to RESP.
//   RESP: rsp_valid=1 for one cycle with rsp_err/rsp_data. Go to IDLE.
//   FLUSH: flush_active for FLUSH_CYC cycles (stk_rst_n low, phase forced to 0).
//    depth<=0, then RESP with err=0.
//  Latency from handshake to rsp_valid:
//   PUSH 3 or 4 cycles (+1 if ALIGN); POP 4 or 5; NOP/error 1; FLUSH FLUSH_CYC+1.
//  depth changes only at PH1 exit or FLUSH. It never wraps: the guards make 0-1 and DEPTH+1
//   unreachable.
//  Because of the one-cycle RESP pulse, at most one command is in flight; cmd_ready is low from
//   handshake through RESP.
//  Reset asserted in any state, including PH0/PH1: the stack is cleared through stk_rst_n, and
//   all master state returns to reset values at the next edge. The pending response is dropped.
//  cmd_op/cmd_data are ignored outside the handshake cycle.
// STRUCTURE
//  Package stack_cmd_pkg: op_e enum (NOP/PUSH/POP/FLUSH), state_e enum, default DW/DEPTH
//   localparams, depth width function clog2(DEPTH+1).
//  Sub-module stack_phase_tracker: phase flop plus the next-phase output that the ALIGN
//   decision uses.
//  Everything else is a single FSM and datapath in this module.
// TESTING
//  1. Reset, then PUSH A5 -> ALIGN present only if required; stk_push high exactly 2 cycles with
//     stk_wdata=A5; depth=1; rsp_valid, err=0.
//  2. PUSH 11, PUSH 22, POP, POP against the stack model -> rsp_data 22 then 11; depth 2->0;
//     empty=1.
//  3. POP on empty -> rsp_valid on the cycle after handshake, rsp_err=1, stk_pop never high,
//     depth stays 0.
//  4. 256 PUSHes of i -> full=1, depth=256; 257th PUSH -> err=1, no strobe; a following POP
//     returns FF.
//  5. Push 3 values, FLUSH -> stk_rst_n low for 1 cycle, depth=0, phase re-aligned; then POP ->
//     err=1; then PUSH 7E/POP -> 7E.
//  6. Reset asserted during PH1 of a PUSH -> stk_push low and stk_rst_n low in that same cycle;
//     no rsp_valid; depth=0; next PUSH/POP round-trip succeeds.

Source files
------------

// File: rtl/stack_cmd_pkg.sv
// Shared types and defaults for the LIFO stack command master.
// The op encoding matches the host-side cmd_op field.
package stack_cmd_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_PUSH  = 2'b01,
        OP_POP   = 2'b10,
        OP_FLUSH = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_PH0,
        S_PH1,
        S_CAPTURE,
        S_RESP,
        S_FLUSH
    } state_e;

    // Occupancy counter must hold 0..depth inclusive.
    function automatic int depth_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_phase_tracker.sv
// Mirror of the stack's internal step toggle. The stack clears its step whenever its
// reset is low, so the mirror follows stk_rst_n rather than the master reset.
module stack_phase_tracker (
    input  logic clk,
    input  logic stk_rst_n,
    output logic phase_nxt
);

    logic phase_q, phase_d;

    always_comb phase_d = stk_rst_n ? ~phase_q : 1'b0;

    always_ff @(posedge clk) phase_q <= phase_d;

    assign phase_nxt = phase_d;

endmodule

// File: rtl/stack_cmd_master.sv
// Command front-end for the two-phase LIFO stack: one command in flight, strobes held
// for exactly one step-0/step-1 pair, occupancy tracked here to refuse over/underflow.
module stack_cmd_master
    import stack_cmd_pkg::*;
#(
    parameter  int DW        = DW_DEF,
    parameter  int DEPTH     = DEPTH_DEF,
    parameter  int FLUSH_CYC = 1,
    localparam int DEPTH_W   = depth_w(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [DW-1:0]      cmd_data,
    output logic               rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [DW-1:0]      stk_wdata,
    input  logic [DW-1:0]      stk_rdata,
    output logic               stk_rst_n,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [DW-1:0]      data_q, data_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [FCW-1:0]     fcnt_q, fcnt_d;
    logic               push_q, push_d, pop_q, pop_d;
    logic               hs, phase_nxt;

    assign cmd_ready = (state_q == S_IDLE);
    assign hs        = cmd_valid & cmd_ready;
    assign full      = (depth_q == DEPTH_W'(DEPTH));
    assign empty     = (depth_q == '0);
    assign stk_rst_n = ~reset & (state_q != S_FLUSH);

    stack_phase_tracker u_phase (
        .clk       (clk),
        .stk_rst_n (stk_rst_n),
        .phase_nxt (phase_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    if (cmd_op == OP_FLUSH)
                        state_d = S_FLUSH;
                    else if (cmd_op == OP_NOP || (cmd_op == OP_PUSH && full) ||
                             (cmd_op == OP_POP && empty))
                        state_d = S_RESP;
                    else
                        state_d = phase_nxt ? S_ALIGN : S_PH0;
                end
            end
            S_ALIGN:   state_d = S_PH0;
            S_PH0:     state_d = S_PH1;
            S_PH1:     state_d = (op_q == OP_POP) ? S_CAPTURE : S_RESP;
            S_CAPTURE: state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            S_FLUSH:   if (fcnt_q == FCW'(FLUSH_CYC - 1)) state_d = S_RESP;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        depth_d    = depth_q;
        fcnt_d     = '0;
        if (hs) begin
            op_d       = op_e'(cmd_op);
            data_d     = cmd_data;
            rsp_data_d = '0;
            rsp_err_d  = (cmd_op == OP_PUSH && full) || (cmd_op == OP_POP && empty);
        end
        case (state_q)
            S_PH1:     depth_d = (op_q == OP_PUSH) ? depth_q + 1'b1 : depth_q - 1'b1;
            S_CAPTURE: rsp_data_d = stk_rdata;
            S_FLUSH: begin
                fcnt_d  = fcnt_q + 1'b1;
                depth_d = '0;
            end
            default: ;
        endcase
        // Strobes are registered off the next state so they cover exactly PH0..PH1.
        push_d = (state_d == S_PH0 || state_d == S_PH1) && (op_d == OP_PUSH);
        pop_d  = (state_d == S_PH0 || state_d == S_PH1) && (op_d == OP_POP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_NOP;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            depth_q    <= '0;
            fcnt_q     <= '0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
        end else begin
            op_q       <= op_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            depth_q    <= depth_d;
            fcnt_q     <= fcnt_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
        end
    end

    // Reset mid-transfer must drop the strobe and response in the same cycle.
    assign stk_push  = push_q & ~reset;
    assign stk_pop   = pop_q & ~reset;
    assign rsp_valid = (state_q == S_RESP) & ~reset;
    assign stk_wdata = data_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign depth     = depth_q;

endmodule
